// File: rtl/router_pkg.sv
// router_pkg: shared defaults and helpers for the router synchroniser slice.
//   ROUTER_NUM_CH   default number of output channels
//   ROUTER_TIMEOUT  default stall timeout in cycles
//   ROUTER_MAX_CH   upper bound on channel count (one-hot decode width)
//   onehot_dec()    address -> one-hot channel select (ROUTER_MAX_CH wide)
//   cnt_width()     stall-counter width able to hold 0..timeout
package router_pkg;

  localparam int unsigned ROUTER_NUM_CH  = 3;
  localparam int unsigned ROUTER_TIMEOUT = 30;
  localparam int unsigned ROUTER_MAX_CH  = 16;

  function automatic logic [ROUTER_MAX_CH-1:0] onehot_dec(input logic [3:0] idx);
    logic [ROUTER_MAX_CH-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// router_sync_timer: one channel's stall counter and soft-reset register.
// Counts consecutive edges where the channel holds valid data that is not
// being read; on the TIMEOUT-th such edge it pulses soft_reset_o for one
// cycle and restarts counting from zero.
// Ports:
//   clock         system clock, rising edge
//   resetn        asynchronous active-low reset
//   vld_i         channel has data (FIFO not empty)
//   read_enb_i    downstream read enable for this channel
//   soft_reset_o  registered one-cycle soft-reset pulse
module router_sync_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (vld_i && !read_enb_i) begin
      // Reaching TIMEOUT wraps straight back to zero on the same edge.
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_sync_multi.sv
// router_sync_multi: parametrised synchroniser between the router FSM and
// NUM_CH output FIFOs. Latches the destination address on detect_add,
// steers write_enb_reg to the addressed FIFO, reflects that FIFO's full
// flag, drives vld_out from the empty flags and issues per-channel soft
// resets when a channel stalls unread for TIMEOUT cycles.
// Optional feature macro: ROUTER_SYNC_ADDR_ERR_EN adds the registered
// addr_err output flagging an out-of-range destination address.
// Ports:
//   clock, resetn   clock (rising edge), asynchronous active-low reset
//   detect_add      header-detect strobe
//   data_in         destination address field (AW bits)
//   write_enb_reg   FSM write request
//   full, empty     per-FIFO status flags
//   read_enb        per-FIFO downstream read enables
//   write_enb       one-hot FIFO write enable
//   fifo_full       full flag of the addressed FIFO
//   vld_out         per-channel data valid
//   soft_reset      per-FIFO soft-reset pulse
//   addr_err        invalid-address flag (ROUTER_SYNC_ADDR_ERR_EN only)
module router_sync_multi
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH  = ROUTER_NUM_CH,
  parameter int unsigned TIMEOUT = ROUTER_TIMEOUT,
  localparam int unsigned AW     = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [AW-1:0]     data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset
`ifdef ROUTER_SYNC_ADDR_ERR_EN
  ,
  output logic              addr_err
`endif
);

  logic [AW-1:0]     addr_q, addr_d;
  logic              addr_ok_q, addr_ok_d;
  logic              data_ok;
  logic [NUM_CH-1:0] sel;

  assign data_ok = (32'(data_in) < NUM_CH);

  always_comb begin
    addr_d    = addr_q;
    addr_ok_d = addr_ok_q;
    if (detect_add) begin
      addr_d    = data_in;
      addr_ok_d = data_ok;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      addr_ok_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      addr_ok_q <= addr_ok_d;
    end
  end

  // Decode from the registered address only, so a detect_add in the same
  // cycle as a write still steers by the previously latched destination.
  always_comb begin
    sel = '0;
    if (addr_ok_q) begin
      sel = NUM_CH'(onehot_dec(4'(addr_q)));
    end
  end

  assign write_enb = write_enb_reg ? sel : '0;
  // Masked reduction avoids indexing full[] with an out-of-range address.
  assign fifo_full = |(full & sel);
  assign vld_out   = ~empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clock        (clock),
      .resetn       (resetn),
      .vld_i        (vld_out[i]),
      .read_enb_i   (read_enb[i]),
      .soft_reset_o (soft_reset[i])
    );
  end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic addr_err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_err_q <= 1'b0;
    end else if (detect_add) begin
      addr_err_q <= ~data_ok;
    end
  end

  assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_router_sync_multi.sv
module tb_router_sync_multi;

  localparam int unsigned NA = 3;
  localparam int unsigned TA = 30;
  localparam int unsigned NB = 5;
  localparam int unsigned TB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn;

  // DUT A: default NUM_CH=3, TIMEOUT=30
  logic          a_detect, a_wer, a_ff;
  logic [1:0]    a_data;
  logic [NA-1:0] a_full, a_empty, a_read, a_we, a_vld, a_sr;
  logic          a_err;

  // DUT B: NUM_CH=5, TIMEOUT=4
  logic          b_detect, b_wer, b_ff;
  logic [2:0]    b_data;
  logic [NB-1:0] b_full, b_empty, b_read, b_we, b_vld, b_sr;
  logic          b_err;

  router_sync_multi #(
    .NUM_CH  (NA),
    .TIMEOUT (TA)
  ) dut_a (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (a_detect),
    .data_in       (a_data),
    .write_enb_reg (a_wer),
    .full          (a_full),
    .empty         (a_empty),
    .read_enb      (a_read),
    .write_enb     (a_we),
    .fifo_full     (a_ff),
    .vld_out       (a_vld),
    .soft_reset    (a_sr)
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    ,
    .addr_err      (a_err)
`endif
  );

  router_sync_multi #(
    .NUM_CH  (NB),
    .TIMEOUT (TB)
  ) dut_b (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (b_detect),
    .data_in       (b_data),
    .write_enb_reg (b_wer),
    .full          (b_full),
    .empty         (b_empty),
    .read_enb      (b_read),
    .write_enb     (b_we),
    .fifo_full     (b_ff),
    .vld_out       (b_vld),
    .soft_reset    (b_sr)
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    ,
    .addr_err      (b_err)
`endif
  );

`ifndef ROUTER_SYNC_ADDR_ERR_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:       return 32'(a_we);
      1:       return 32'(a_ff);
      2:       return 32'(a_vld);
      3:       return 32'(a_sr);
      4:       return 32'(a_err);
      5:       return 32'(b_we);
      6:       return 32'(b_sr);
      7:       return 32'(b_ff);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    a_detect = 1'b0; a_data = '0; a_wer = 1'b0;
    a_full   = '0;   a_empty = '1; a_read = '0;
    b_detect = 1'b0; b_data = '0; b_wer = 1'b0;
    b_full   = '0;   b_empty = '1; b_read = '0;

    // Reset state
    push_exp("rst_we", 0, 0);
    push_exp("rst_ff", 1, 0);
    push_exp("rst_vld", 2, 0);
    push_exp("rst_sr", 3, 0);
    push_exp("rst_err", 4, 0);
    push_exp("rst_b_we", 5, 0);
    drain();
    step();
    resetn = 1'b1;

    // Latch address 2, steer write, full flag selection
    a_detect = 1'b1; a_data = 2'd2;
    step();
    a_detect = 1'b0; a_wer = 1'b1;
    push_exp("we_addr2", 0, 3'b100);
    push_exp("ff_none", 1, 0);
    drain();
    a_full = 3'b100;
    push_exp("ff_sel2", 1, 1);
    drain();
    a_full = 3'b001;
    push_exp("ff_other", 1, 0);
    drain();
    a_empty = 3'b010;
    push_exp("vld_map", 2, 3'b101);
    drain();
    a_empty = '1; a_full = '0; a_wer = 1'b0;

    // Same-cycle detect_add and write: old address governs that cycle
    a_detect = 1'b1; a_data = 2'd0;
    step();
    a_data = 2'd1; a_wer = 1'b1;
    push_exp("same_cyc_old", 0, 3'b001);
    drain();
    step();
    a_detect = 1'b0;
    push_exp("same_cyc_new", 0, 3'b010);
    drain();

    // Out-of-range address suppresses steering
    a_wer = 1'b0; a_detect = 1'b1; a_data = 2'd3;
    step();
    a_detect = 1'b0; a_wer = 1'b1; a_full = '1;
    push_exp("bad_we", 0, 0);
    push_exp("bad_ff", 1, 0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    push_exp("err_set", 4, 1);
`endif
    drain();
    a_detect = 1'b1; a_data = 2'd0;
    step();
    a_detect = 1'b0;
    push_exp("good_we", 0, 3'b001);
    push_exp("good_ff", 1, 1);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    push_exp("err_clr", 4, 0);
`endif
    drain();
    a_wer = 1'b0; a_full = '0;

    // Channel 1 stall: pulses at edges 30 and 60
    a_empty = 3'b101; a_read = '0;
    for (int e = 1; e <= 60; e++) begin
      step();
      push_exp($sformatf("stall_e%0d", e), 3, (e == 30 || e == 60) ? 3'b010 : 3'b000);
      drain();
    end

    // Restart, read on the edge that would reach TIMEOUT: no pulse there
    a_empty = '1;
    step();
    a_empty = 3'b101;
    for (int e = 1; e <= 60; e++) begin
      a_read = (e == 30) ? 3'b010 : 3'b000;
      step();
      push_exp($sformatf("rdclr_e%0d", e), 3, (e == 60) ? 3'b010 : 3'b000);
      drain();
    end
    a_read = '0;

    // Reset mid-packet with counter at 20
    a_empty = '1; a_detect = 1'b1; a_data = 2'd1;
    step();
    a_detect = 1'b0; a_wer = 1'b1; a_full = 3'b010; a_empty = 3'b101;
    for (int e = 1; e <= 20; e++) step();
    push_exp("pre_rst_we", 0, 3'b010);
    push_exp("pre_rst_ff", 1, 1);
    drain();
    resetn = 1'b0;
    push_exp("mid_rst_we", 0, 0);
    push_exp("mid_rst_ff", 1, 0);
    push_exp("mid_rst_sr", 3, 0);
    drain();
    resetn = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 1) push_exp("post_rst_we", 0, 0);
      push_exp($sformatf("post_rst_e%0d", e), 3, (e == 30) ? 3'b010 : 3'b000);
      drain();
    end
    a_wer = 1'b0; a_empty = '1; a_full = '0;

    // DUT B: decode every address
    for (int a = 0; a < int'(NB); a++) begin
      b_detect = 1'b1; b_data = 3'(a);
      step();
      b_detect = 1'b0; b_wer = 1'b1;
      b_full = NB'(1) << a;
      push_exp($sformatf("b_we_a%0d", a), 5, 32'(1) << a);
      push_exp($sformatf("b_ff_a%0d", a), 7, 1);
      drain();
      b_wer = 1'b0; b_full = '0;
    end

    // DUT B: all channels stall together
    b_empty = '0; b_read = '0;
    for (int e = 1; e <= 8; e++) begin
      step();
      push_exp($sformatf("b_stall_e%0d", e), 6, (e % 4 == 0) ? 5'b11111 : 5'b00000);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
